armstrong_scanner: RTL and testbench

Sequential controller that scans an inclusive range of 3-digit decimal values and streams out every Armstrong number found, where a value equals the sum of the cubes of its decimal digits. It sits in front of the digit-split/cube-sum datapath and runs it one candidate at a time. It shares a single cube unit across the three digits over successive cycles. Results leave through a valid/ready handshake, and a running hit count is reported.

---
 rtl/armstrong_scanner.sv | 167 ++++++++++++++++
 tb/tb_armstrong_scanner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/armstrong_scanner.sv
`default_nettype none
// ============================================================================
// Module      : armstrong_scanner
// Description : Scans an inclusive range of 3-digit values, one candidate per
//               five cycles, and streams out every Armstrong number found.
// Revision    : 1.0 - initial release
// ============================================================================
module armstrong_scanner (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] lo,
    input  logic [9:0] hi,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [9:0] out_num,
    output logic       busy,
    output logic       done,
    output logic [3:0] count
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SPLIT = 3'd1;
    localparam logic [2:0] c_ST_CUBE0 = 3'd2;
    localparam logic [2:0] c_ST_CUBE1 = 3'd3;
    localparam logic [2:0] c_ST_CUBE2 = 3'd4;
    localparam logic [2:0] c_ST_CHECK = 3'd5;
    localparam logic [2:0] c_ST_EMIT  = 3'd6;
    localparam logic [2:0] c_ST_DONE  = 3'd7;

    localparam logic [9:0] c_MAX_VAL   = 10'd999;
    localparam logic [3:0] c_COUNT_MAX = 4'd15;

    logic [2:0]  r_state;
    logic [9:0]  r_cur;
    logic [9:0]  r_hi;
    logic [3:0]  r_d0;
    logic [3:0]  r_d1;
    logic [3:0]  r_d2;
    logic [11:0] r_sum;
    logic [3:0]  r_count;
    logic        r_out_valid;
    logic [9:0]  r_out_num;
    logic        r_busy;
    logic        r_done;

    logic [9:0]  w_hi_clamped;
    logic [3:0]  w_cube_digit;
    logic [9:0]  w_cube_digit_ext;
    logic [9:0]  w_cube;
    logic        w_last;

    assign w_hi_clamped = (hi > c_MAX_VAL) ? c_MAX_VAL : hi;
    assign w_last       = (r_cur == r_hi);

    // Single shared cube unit; the state selects which digit it sees.
    always_comb begin
        w_cube_digit = r_d0;
        case (r_state)
            c_ST_CUBE1: w_cube_digit = r_d1;
            c_ST_CUBE2: w_cube_digit = r_d2;
            default:    w_cube_digit = r_d0;
        endcase
    end

    assign w_cube_digit_ext = {6'd0, w_cube_digit};
    assign w_cube           = w_cube_digit_ext * w_cube_digit_ext * w_cube_digit_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cur       <= 10'd0;
            r_hi        <= 10'd0;
            r_d0        <= 4'd0;
            r_d1        <= 4'd0;
            r_d2        <= 4'd0;
            r_sum       <= 12'd0;
            r_count     <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_num   <= 10'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_hi    <= w_hi_clamped;
                        r_cur   <= lo;
                        r_count <= 4'd0;
                        r_busy  <= 1'b1;
                        if (lo > w_hi_clamped) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_ST_SPLIT;
                        end
                    end
                end
                c_ST_SPLIT: begin
                    r_d0    <= 4'(r_cur % 10'd10);
                    r_d1    <= 4'((r_cur / 10'd10) % 10'd10);
                    r_d2    <= 4'(r_cur / 10'd100);
                    r_sum   <= 12'd0;
                    r_state <= c_ST_CUBE0;
                end
                c_ST_CUBE0: begin
                    r_sum   <= r_sum + {2'b00, w_cube};
                    r_state <= c_ST_CUBE1;
                end
                c_ST_CUBE1: begin
                    r_sum   <= r_sum + {2'b00, w_cube};
                    r_state <= c_ST_CUBE2;
                end
                c_ST_CUBE2: begin
                    r_sum   <= r_sum + {2'b00, w_cube};
                    r_state <= c_ST_CHECK;
                end
                c_ST_CHECK: begin
                    // Full 12-bit compare so sums above 1023 can never alias onto cur.
                    if (r_sum == {2'b00, r_cur}) begin
                        r_state     <= c_ST_EMIT;
                        r_out_valid <= 1'b1;
                        r_out_num   <= r_cur;
                    end else if (w_last) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cur   <= r_cur + 10'd1;
                        r_state <= c_ST_SPLIT;
                    end
                end
                c_ST_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_count != c_COUNT_MAX) begin
                            r_count <= r_count + 4'd1;
                        end
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cur   <= r_cur + 10'd1;
                            r_state <= c_ST_SPLIT;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_num   = r_out_num;
    assign busy      = r_busy;
    assign done      = r_done;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_armstrong_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_armstrong_scanner
// Description : Self-checking bench for armstrong_scanner against a digit-cube
//               reference model, with directed and randomized scans.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_armstrong_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] lo = 10'd0;
    logic [9:0] hi = 10'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [9:0] out_num;
    logic       busy;
    logic       done;
    logic [3:0] count;

    int n_vec = 0;
    int n_err = 0;

    armstrong_scanner u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_num   (out_num),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_armstrong(input int v);
        int a, b, c;
        a = v / 100;
        b = (v / 10) % 10;
        c = v % 10;
        return (a * a * a + b * b * b + c * c * c) == v;
    endfunction

    function automatic int sat15(input int n);
        return (n > 15) ? 15 : n;
    endfunction

    // bp_mode: 0 = always ready, 1 = random ready, 2 = ready low for first 10 valid cycles
    task automatic run_scan(input int lo_v, input int hi_v, input int bp_mode, input bit noise);
        int  exp_q[$];
        int  got_q[$];
        int  hi_c, n_cand, k, stalls, low_run, last_num, exp_done_k;
        bit  seen_done, prev_valid, rdy;
        hi_c = (hi_v > 999) ? 999 : hi_v;
        n_cand = (lo_v > hi_c) ? 0 : (hi_c - lo_v + 1);
        for (int v = lo_v; v <= hi_c; v++) if (is_armstrong(v)) exp_q.push_back(v);
        stalls = 0; low_run = 0; last_num = 0; seen_done = 0; prev_valid = 0;

        @(negedge clk);
        lo = 10'(lo_v); hi = 10'(hi_v); start = 1'b1; out_ready = (bp_mode == 0);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        check("busy_after_start", busy, 1);
        while (k <= 30000) begin
            check("count_running", count, sat15(got_q.size()));
            check("valid_done_excl", out_valid & done, 0);
            if (done) begin
                seen_done = 1;
                break;
            end
            if (out_valid && prev_valid) check("num_stable", out_num, last_num);
            last_num = out_num;
            case (bp_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom % 3) != 0;
                default: rdy = (low_run >= 10);
            endcase
            out_ready = rdy;
            if (out_valid) begin
                low_run++;
                if (rdy) got_q.push_back(int'(out_num));
                else stalls++;
            end
            prev_valid = out_valid && !rdy;
            if (noise) begin
                start = (($urandom % 3) == 0);
                lo = 10'($urandom % 1024);
                hi = 10'($urandom % 1024);
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        exp_done_k = 1 + 5 * n_cand + exp_q.size() + stalls;
        check("done_cycle", k, exp_done_k);
        check("busy_in_done", busy, 1);
        check("count_final", count, sat15(exp_q.size()));
        check("num_outputs", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("out_value", got_q[i], exp_q[i]);
        @(negedge clk);
        check("busy_idle", busy, 0);
        check("done_pulse_len", done, 0);
        check("count_hold", count, sat15(exp_q.size()));
    endtask

    initial begin
        int r_lo, r_hi;
        // reset values
        @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_num", out_num, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;

        run_scan(150, 160, 0, 0);
        run_scan(0, 999, 0, 0);
        run_scan(153, 153, 2, 0);
        run_scan(500, 400, 0, 0);
        run_scan(990, 1023, 0, 0);
        run_scan(360, 410, 1, 1);

        for (int t = 0; t < 4; t++) begin
            r_lo = $urandom_range(0, 950);
            r_hi = r_lo + $urandom_range(0, 120);
            run_scan(r_lo, r_hi, 1, 0);
        end
        run_scan(0, 1023, 1, 0);

        // Reset while 370 is stalled in EMIT.
        @(negedge clk);
        lo = 10'd0; hi = 10'd999; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!(out_valid && out_num == 10'd370) && guard < 10000) begin
                out_ready = 1'b1;
                @(negedge clk);
                guard++;
            end
            out_ready = 1'b0;
            check("reach_emit_370", out_valid && out_num == 10'd370, 1);
        end
        #2 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_num", out_num, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_count", count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("arst_hold_valid", out_valid, 0);
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_scan(370, 371, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
